arm_mc_controller: RTL and testbench
====================================

// Module: arm_mc_controller
// PURPOSE
//  Multicycle control unit for the ARMv4-subset core: ADD/SUB/AND/ORR/CMP/TST, LDR/STR, B.
//  Sequences one shared-memory datapath (single ALU, IR, ALUOut, Data regs) through
//  FETCH/DECODE/EXECUTE/WRITEBACK; holds NZCV flags and a registered condition result.
//  Sits beside the multicycle datapath in the arm top; drives all mux selects and write enables.
// PARAMETERS
//  none (encodings fixed in arm_mc_pkg)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high
//  Instr       in   20  IR[31:12]: cond, op, funct, Rd
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  PCWrite     out  1   load PC from Result
//  AdrSrc      out  1   mem addr: 0=PC, 1=Result
//  MemWrite    out  1   data memory write strobe
//  IRWrite     out  1   load instruction register
//  ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  1   0=RD1, 1=PC
//  ALUSrcB     out  2   00=RD2, 01=ExtImm, 10=const 4
//  ALUControl  out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//  ImmSrc      out  2   00 imm8, 01 imm12, 10 branch imm24
//  RegSrc      out  2   [0]=RA1<-R15, [1]=RA2<-Rd
//  RegWrite    out  1   register file write strobe
//  State       out  4   current FSM state (debug/verification)
// BEHAVIOUR
//  Reset: State=FETCH; Flags=0000; CondExR=0; PCWrite/IRWrite/MemWrite/RegWrite=0 while reset high.
//  States/transitions (all others 1 cycle, unconditional):
//   FETCH   : AdrSrc0, IRWrite, ALUSrcA1, ALUSrcB10, ADD, ResultSrc10, PCWrite -> DECODE
//   DECODE  : ALUSrcA1, ALUSrcB10, ADD, ResultSrc10; latch CondExR=condcheck(cond,Flags)
//             op00&I -> EXECI; op00&~I -> EXECR; op01 -> MEMADR; op10 -> BRANCH; op11 -> FETCH
//   EXECR   : ALUSrcB00, ALUControl from funct[4:1] -> ALUWB
//   EXECI   : ALUSrcB01, ImmSrc00, ALUControl from funct[4:1] -> ALUWB
//   ALUWB   : ResultSrc00; RegWrite=CondExR & ~NoWrite -> FETCH
//   MEMADR  : ALUSrcB01, ImmSrc01, ADD -> L ? MEMRD : MEMWR
//   MEMRD   : AdrSrc1, ResultSrc00 -> MEMWB
//   MEMWB   : ResultSrc01, RegWrite=CondExR -> FETCH
//   MEMWR   : AdrSrc1, ResultSrc00, MemWrite=CondExR -> FETCH
//   BRANCH  : ALUSrcB01, ImmSrc10, ADD, ResultSrc10, PCWrite=CondExR -> FETCH
//  Latency (cycles): DP 4, CMP/TST 4, LDR 5, STR 4, B 3, op11 2.
//  ALU decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP(SUB), 1000 TST(AND); other -> ADD, no write.
//  NoWrite = CMP|TST|unsupported funct. RegSrc = {op==01, op==10} held DECODE..end of instr.
//  Flags: at end of EXECR/EXECI, if S & CondExR: NZ<-ALUFlags[3:2]; CV<-ALUFlags[1:0] only for ADD/SUB/CMP.
//  Flag update in EXECUTE never changes CondExR of same instruction (latched in DECODE).
//  Rd==15 with RegWrite in ALUWB/MEMWB also asserts PCWrite (same cycle, same condition).
//  Cond 1111: CondExR=0 (never). Unused outputs: 0, never X.
//  Reset mid-instruction: returns to FETCH asynchronously; no partial write may complete after release.
// STRUCTURE
//  arm_mc_pkg: typedef enum logic[3:0] state_t (FETCH=0,DECODE,MEMADR,MEMRD,MEMWB,MEMWR,EXECR,
//   EXECI,ALUWB,BRANCH); ALU op, ResultSrc, ALUSrcB, ImmSrc localparams; funct code constants.
//  Sub-module arm_mc_mainfsm: state register + per-state control decode; top adds ALU decoder,
//   Flags/CondExR registers and reuses existing condcheck.
// TESTING
//  Reset 3 cycles, release -> State=FETCH, IRWrite=1, PCWrite=1 first cycle, Flags=0000.
//  ADDS R1,R0,#5 (E2901005) -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in ALUWB; 4 cycles.
//  CMP R1,#5 then BEQ (0A000001) -> Z=1, RegWrite=0 in ALUWB, BRANCH asserts PCWrite.
//  BNE with Z=1 -> 3 cycles, PCWrite=0 in BRANCH; STRNE -> MemWrite=0 in MEMWR.
//  LDR R2,[R0,#96] -> MEMADR ImmSrc01, MEMRD AdrSrc1, MEMWB ResultSrc01 RegWrite=1; 5 cycles.
//  Assert reset during MEMWR -> MemWrite falls same cycle; State=FETCH, no store observed.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the state enum, control-word struct, select encodings and condition check.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_t;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmDp  = 2'b00;
  localparam logic [1:0] ImmMem = 2'b01;
  localparam logic [1:0] ImmBr  = 2'b10;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdTst = 4'b1000;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '{
    pc_write: 1'b0, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b0,
    result_src: ResAluOut, alu_src_a: 1'b0, alu_src_b: SrcBRd2,
    alu_control: AluAdd, imm_src: ImmDp, reg_write: 1'b0
  };

  localparam ctrl_t CtrlFetch = '{
    pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b1,
    result_src: ResAluResult, alu_src_a: 1'b1, alu_src_b: SrcBFour,
    alu_control: AluAdd, imm_src: ImmDp, reg_write: 1'b0
  };

  // flags = {N, Z, C, V}
  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, ge;
    {n, z, c, v} = flags;
    ge = (n == v);
    case (cond)
      4'b0000: condcheck = z;
      4'b0001: condcheck = ~z;
      4'b0010: condcheck = c;
      4'b0011: condcheck = ~c;
      4'b0100: condcheck = n;
      4'b0101: condcheck = ~n;
      4'b0110: condcheck = v;
      4'b0111: condcheck = ~v;
      4'b1000: condcheck = c & ~z;
      4'b1001: condcheck = ~c | z;
      4'b1010: condcheck = ge;
      4'b1011: condcheck = ~ge;
      4'b1100: condcheck = ~z & ge;
      4'b1101: condcheck = z | ~ge;
      4'b1110: condcheck = 1'b1;
      default: condcheck = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface arm_mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );
endinterface

// File: rtl/arm_mc_mainfsm.sv
// Main sequencer: state register plus a registered control word for the state being entered.
module arm_mc_mainfsm
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic       cond_ex,
  input  logic       no_write,
  input  logic [1:0] alu_dec,
  output state_t     state,
  output ctrl_t      ctrl,
  output logic [1:0] reg_src
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      default:  state_d = StFetch;
    endcase

    // Control word is computed for the state being entered so outputs come straight from flops.
    ctrl_d = CtrlIdle;
    case (state_d)
      StFetch:  ctrl_d = CtrlFetch;
      StDecode: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_src_b  = SrcBFour;
        ctrl_d.result_src = ResAluResult;
      end
      StExecR:  ctrl_d.alu_control = alu_dec;
      StExecI: begin
        ctrl_d.alu_src_b   = SrcBImm;
        ctrl_d.imm_src     = ImmDp;
        ctrl_d.alu_control = alu_dec;
      end
      StAluWb: begin
        ctrl_d.reg_write = cond_ex & ~no_write;
        ctrl_d.pc_write  = cond_ex & ~no_write & (rd == 4'hf);
      end
      StMemAdr: begin
        ctrl_d.alu_src_b = SrcBImm;
        ctrl_d.imm_src   = ImmMem;
      end
      StMemRd:  ctrl_d.adr_src = 1'b1;
      StMemWb: begin
        ctrl_d.result_src = ResData;
        ctrl_d.reg_write  = cond_ex;
        ctrl_d.pc_write   = cond_ex & (rd == 4'hf);
      end
      StMemWr: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = cond_ex;
      end
      StBranch: begin
        ctrl_d.alu_src_b  = SrcBImm;
        ctrl_d.imm_src    = ImmBr;
        ctrl_d.result_src = ResAluResult;
        ctrl_d.pc_write   = cond_ex;
      end
      default: ctrl_d = CtrlIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= CtrlFetch;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // IR only holds the new instruction once FETCH has ended, so this stays combinational.
  assign reg_src = (state_q == StFetch) ? 2'b00 : {op == 2'b01, op == 2'b10};
  assign state   = state_q;
  assign ctrl    = ctrl_q;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle control unit: ALU decode, NZCV flags, latched condition and the main sequencer.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  arm_mc_controller_if.master bus
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign cmd       = funct[4:1];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  logic [1:0] alu_dec;
  logic       no_write, arith;

  always_comb begin
    alu_dec  = AluAdd;
    no_write = 1'b1;
    arith    = 1'b0;
    case (cmd)
      CmdAdd: begin alu_dec = AluAdd; no_write = 1'b0; arith = 1'b1; end
      CmdSub: begin alu_dec = AluSub; no_write = 1'b0; arith = 1'b1; end
      CmdAnd: begin alu_dec = AluAnd; no_write = 1'b0; end
      CmdOrr: begin alu_dec = AluOrr; no_write = 1'b0; end
      CmdCmp: begin alu_dec = AluSub; arith = 1'b1; end
      CmdTst: alu_dec = AluAnd;
      default: ;
    endcase
  end

  state_t     state;
  ctrl_t      ctrl;
  logic [1:0] reg_src;
  logic [3:0] flags_q;
  logic       cond_ex_q, cond_ex;

  // In DECODE the latch is still being loaded, so successors see the live check.
  assign cond_ex = (state == StDecode) ? condcheck(cond, flags_q) : cond_ex_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (state == StDecode) cond_ex_q <= condcheck(cond, flags_q);
      if ((state == StExecR || state == StExecI) && funct[0] && cond_ex_q) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        if (arith) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  arm_mc_mainfsm u_mainfsm (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .rd       (rd),
    .cond_ex  (cond_ex),
    .no_write (no_write),
    .alu_dec  (alu_dec),
    .state    (state),
    .ctrl     (ctrl),
    .reg_src  (reg_src)
  );

  // Strobes are gated so an asserted reset kills any write in the same cycle.
  assign bus.PCWrite    = ctrl.pc_write & ~reset;
  assign bus.IRWrite    = ctrl.ir_write & ~reset;
  assign bus.MemWrite   = ctrl.mem_write & ~reset;
  assign bus.RegWrite   = ctrl.reg_write & ~reset;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = ctrl.alu_control;
  assign bus.ImmSrc     = ctrl.imm_src;
  assign bus.RegSrc     = reg_src;
  assign bus.State      = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for the multicycle controller: walks instructions state by state.
module tb_arm_mc_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  arm_mc_controller_if bus ();

  arm_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] st);
    @(negedge clk);
    #1;
    check({tag, ".state"}, 32'(bus.State), 32'(st));
  endtask

  // Called while in FETCH: checks fetch controls and presents the next IR contents.
  task automatic load(input string tag, input logic [31:0] ir);
    check({tag, ".fetch_state"}, 32'(bus.State), 32'd0);
    check({tag, ".fetch_irwrite"}, 32'(bus.IRWrite), 32'd1);
    check({tag, ".fetch_pcwrite"}, 32'(bus.PCWrite), 32'd1);
    check({tag, ".fetch_srcb"}, 32'(bus.ALUSrcB), 32'd2);
    check({tag, ".fetch_res"}, 32'(bus.ResultSrc), 32'd2);
    bus.Instr = ir[31:12];
  endtask

  initial begin
    reset        = 1'b1;
    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.state", 32'(bus.State), 32'd0);
      check("rst.strobes", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
    end
    reset = 1'b0;
    #1;

    // ADDS R1,R0,#5
    load("adds", 32'hE2901005);
    step("adds.dec", 4'd1);
    check("adds.dec_regsrc", 32'(bus.RegSrc), 32'd0);
    check("adds.dec_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("adds.dec_irwrite", 32'(bus.IRWrite), 32'd0);
    step("adds.exe", 4'd7);
    check("adds.exe_srcb", 32'(bus.ALUSrcB), 32'd1);
    check("adds.exe_aluctl", 32'(bus.ALUControl), 32'd0);
    check("adds.exe_regwrite", 32'(bus.RegWrite), 32'd0);
    bus.ALUFlags = 4'b0000;
    step("adds.wb", 4'd8);
    check("adds.wb_regwrite", 32'(bus.RegWrite), 32'd1);
    check("adds.wb_res", 32'(bus.ResultSrc), 32'd0);
    check("adds.wb_pcwrite", 32'(bus.PCWrite), 32'd0);
    step("adds.end", 4'd0);

    // CMP R1,#5 with equal operands
    load("cmp", 32'hE3510005);
    step("cmp.dec", 4'd1);
    step("cmp.exe", 4'd7);
    check("cmp.exe_aluctl", 32'(bus.ALUControl), 32'd1);
    bus.ALUFlags = 4'b0110;
    step("cmp.wb", 4'd8);
    check("cmp.wb_regwrite", 32'(bus.RegWrite), 32'd0);
    bus.ALUFlags = 4'b0000;
    step("cmp.end", 4'd0);

    // BEQ taken
    load("beq", 32'h0A000001);
    step("beq.dec", 4'd1);
    check("beq.dec_regsrc", 32'(bus.RegSrc), 32'd1);
    step("beq.br", 4'd9);
    check("beq.br_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("beq.br_imm", 32'(bus.ImmSrc), 32'd2);
    check("beq.br_res", 32'(bus.ResultSrc), 32'd2);
    step("beq.end", 4'd0);

    // BNE not taken
    load("bne", 32'h1A000001);
    step("bne.dec", 4'd1);
    step("bne.br", 4'd9);
    check("bne.br_pcwrite", 32'(bus.PCWrite), 32'd0);
    step("bne.end", 4'd0);

    // STRNE R2,[R0,#4] suppressed
    load("strne", 32'h15802004);
    step("strne.dec", 4'd1);
    step("strne.adr", 4'd2);
    check("strne.adr_imm", 32'(bus.ImmSrc), 32'd1);
    check("strne.adr_regsrc", 32'(bus.RegSrc), 32'd2);
    step("strne.wr", 4'd5);
    check("strne.wr_memwrite", 32'(bus.MemWrite), 32'd0);
    check("strne.wr_adrsrc", 32'(bus.AdrSrc), 32'd1);
    step("strne.end", 4'd0);

    // LDR R2,[R0,#96]
    load("ldr", 32'hE5902060);
    step("ldr.dec", 4'd1);
    step("ldr.adr", 4'd2);
    check("ldr.adr_imm", 32'(bus.ImmSrc), 32'd1);
    step("ldr.rd", 4'd3);
    check("ldr.rd_adrsrc", 32'(bus.AdrSrc), 32'd1);
    check("ldr.rd_res", 32'(bus.ResultSrc), 32'd0);
    step("ldr.wb", 4'd4);
    check("ldr.wb_res", 32'(bus.ResultSrc), 32'd1);
    check("ldr.wb_regwrite", 32'(bus.RegWrite), 32'd1);
    check("ldr.wb_pcwrite", 32'(bus.PCWrite), 32'd0);
    step("ldr.end", 4'd0);

    // op=11 unsupported: two cycles
    load("op11", 32'hEC000000);
    step("op11.dec", 4'd1);
    step("op11.end", 4'd0);

    // Cond 1111 branch never taken
    load("bnv", 32'hFA000001);
    step("bnv.dec", 4'd1);
    step("bnv.br", 4'd9);
    check("bnv.br_pcwrite", 32'(bus.PCWrite), 32'd0);
    step("bnv.end", 4'd0);

    // ORR PC,R0,R1: register write to R15 also loads PC
    load("orrpc", 32'hE180F001);
    step("orrpc.dec", 4'd1);
    step("orrpc.exe", 4'd6);
    check("orrpc.exe_srcb", 32'(bus.ALUSrcB), 32'd0);
    check("orrpc.exe_aluctl", 32'(bus.ALUControl), 32'd3);
    step("orrpc.wb", 4'd8);
    check("orrpc.wb_regwrite", 32'(bus.RegWrite), 32'd1);
    check("orrpc.wb_pcwrite", 32'(bus.PCWrite), 32'd1);
    step("orrpc.end", 4'd0);

    // STR R2,[R0,#4] interrupted by reset in MEMWR
    load("strrst", 32'hE5802004);
    step("strrst.dec", 4'd1);
    step("strrst.adr", 4'd2);
    step("strrst.wr", 4'd5);
    check("strrst.wr_memwrite", 32'(bus.MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("strrst.rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("strrst.rst_state", 32'(bus.State), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("strrst.rel_memwrite", 32'(bus.MemWrite), 32'd0);

    // Flags cleared by reset: BEQ must not be taken
    load("beq0", 32'h0A000001);
    step("beq0.dec", 4'd1);
    step("beq0.br", 4'd9);
    check("beq0.br_pcwrite", 32'(bus.PCWrite), 32'd0);
    step("beq0.end", 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
